debounce_array: RTL and testbench
=================================

DEBOUNCE_ARRAY -- requirements
Module: debounce_array

Interface
REQ-001 SHALL have parameter N_CH, default 4, number of independent input channels (1..32).
REQ-002 SHALL have parameter DEBOUNCE_INTERVAL, default 250000, settle/lockout length in clk cycles (>=2).
REQ-003 SHALL have parameter SYNC_STAGES, default 2, input synchroniser depth (0 = bypass, else 2..4).
REQ-004 SHALL have parameter MODE, default 0, filter mode: 0 = stable-count, 1 = lockout.
REQ-005 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-006 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-007 SHALL have port in  input  N_CH  raw asynchronous channel inputs.
REQ-008 SHALL have port out  output  N_CH  debounced level per channel, registered.
REQ-009 SHALL have port rise  output  N_CH  one-cycle pulse, same cycle out[i] goes 0->1.
REQ-010 SHALL have port fall  output  N_CH  one-cycle pulse, same cycle out[i] goes 1->0.
REQ-011 SHALL have port changed  output  1  OR of rise and fall across all channels.

Function
REQ-012 SHALL process each channel independently, with its own synchroniser, counter and state; no channel shall affect another.
REQ-013 SHALL pass in[i] through SYNC_STAGES flops to form s[i]; with SYNC_STAGES=0, s[i]=in[i] combinationally.
REQ-014 SHALL size each counter at $clog2(DEBOUNCE_INTERVAL+1) bits; counter never exceeds DEBOUNCE_INTERVAL-1 in MODE 0 or DEBOUNCE_INTERVAL in MODE 1.
REQ-015 MODE 0: while s[i]==out[i], cnt[i] SHALL be 0.
REQ-016 MODE 0: while s[i]!=out[i] and cnt[i]<DEBOUNCE_INTERVAL-1, cnt[i] SHALL increment by 1 per cycle.
REQ-017 MODE 0: when s[i]!=out[i] and cnt[i]==DEBOUNCE_INTERVAL-1, out[i] SHALL load s[i] and cnt[i] SHALL clear to 0, i.e. out[i] updates exactly DEBOUNCE_INTERVAL cycles after s[i] first differs, provided no intervening match.
REQ-018 MODE 0: any single cycle with s[i]==out[i] SHALL clear cnt[i] to 0 and restart qualification (glitch rejection).
REQ-019 MODE 1: channel SHALL have states IDLE and LOCK.
REQ-020 MODE 1 IDLE: if s[i]!=out[i], out[i] SHALL load s[i] on the next edge and the channel SHALL enter LOCK with cnt[i]=1; else remain IDLE with cnt[i]=0.
REQ-021 MODE 1 LOCK: s[i] SHALL be ignored; cnt[i] increments each cycle; when cnt[i]==DEBOUNCE_INTERVAL the channel SHALL return to IDLE with cnt[i]=0.
REQ-022 MODE 1: if s[i]!=out[i] on the first IDLE cycle after LOCK, out[i] SHALL update on that edge (minimum spacing between out[i] transitions = DEBOUNCE_INTERVAL+1 cycles).
REQ-023 rise[i]/fall[i] SHALL be registered, asserted in the same cycle out[i] shows its new value, and deasserted the following cycle.
REQ-024 changed SHALL be registered alongside rise/fall, never combinational from in.
REQ-025 Simultaneous qualification on several channels SHALL update all of them in the same cycle with the corresponding rise/fall bits set together.

Reset
REQ-026 During rst, every synchroniser stage and out[i] SHALL load in[i], so no edge is reported on reset release.
REQ-027 During rst, cnt[i]=0, MODE 1 state=IDLE, rise=fall=0, changed=0.
REQ-028 rst asserted mid-qualification or mid-LOCK SHALL abandon it; after release, behaviour SHALL be as from power-up with out=in.

Verification
REQ-029 MODE 0, N_CH=4, DEBOUNCE_INTERVAL=8, SYNC_STAGES=2: reset with in=4'b0000, raise in[0] and hold -> out[0]=1 and rise[0]=1 for one cycle exactly 10 cycles after the in edge (2 sync + 8), changed=1 that cycle, other bits 0.
REQ-030 Same config: in[1] high for 7 cycles, low 1, high 7 -> out[1] stays 0, no rise[1]; then hold high -> out[1]=1 8 cycles after s[1] last rose.
REQ-031 Same config: in=4'b1111 released to 4'b0000 on one edge after settling high -> fall=4'b1111 in a single cycle, out=4'b0000.
REQ-032 MODE 1, DEBOUNCE_INTERVAL=8, SYNC_STAGES=0: in[2] toggles every cycle for 20 cycles from 0 -> out[2] transitions only at cycles 1, 10, 19 relative to first toggle, each with one rise/fall pulse.
REQ-033 Reset with in=4'b1010 held -> after release out=4'b1010, rise=fall=0, changed=0 for all cycles while in is steady.
REQ-034 MODE 0: rst pulsed when cnt[3]=5 during a 0->1 qualification with in[3]=1 -> out[3]=1 right after reset, no rise[3] pulse.

Source files
------------

// File: rtl/debounce_array.sv
// Per-channel input debouncer: optional synchroniser, then either a stable-count
// filter (MODE 0) or a change-then-lockout filter (MODE 1), with edge pulses.
module debounce_array #(
  parameter int unsigned N_CH              = 4,
  parameter int unsigned DEBOUNCE_INTERVAL = 250000,
  parameter int unsigned SYNC_STAGES       = 2,
  parameter int unsigned MODE              = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] in,
  output logic [N_CH-1:0] out,
  output logic [N_CH-1:0] rise,
  output logic [N_CH-1:0] fall,
  output logic            changed
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_INTERVAL + 1);

  logic [N_CH-1:0] s;
  logic [N_CH-1:0] out_q;
  logic [N_CH-1:0] out_d;
  logic [N_CH-1:0] rise_q;
  logic [N_CH-1:0] fall_q;
  logic            changed_q;

  // Synchroniser stages preload the raw input in reset so release reports no edge.
  if (SYNC_STAGES == 0) begin : g_nosync
    assign s = in;
  end else begin : g_sync
    logic [N_CH-1:0] sync_q [SYNC_STAGES];

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int unsigned k = 0; k < SYNC_STAGES; k++) sync_q[k] <= in;
      end else begin
        sync_q[0] <= in;
        for (int unsigned k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
      end
    end

    assign s = sync_q[SYNC_STAGES-1];
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             out_nxt;

    assign out_d[i] = out_nxt;

    if (MODE == 0) begin : g_stable
      localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_INTERVAL - 1);

      // Any cycle where the input matches the output restarts qualification.
      always_comb begin
        cnt_d   = '0;
        out_nxt = out_q[i];
        if (s[i] != out_q[i]) begin
          if (cnt_q == CNT_LAST) out_nxt = s[i];
          else                   cnt_d   = cnt_q + CNT_W'(1);
        end
      end

      always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
      end
    end else begin : g_lock
      localparam logic [CNT_W-1:0] CNT_LOCK = CNT_W'(DEBOUNCE_INTERVAL);

      typedef enum logic {IDLE, LOCK} state_e;
      state_e state_q;
      state_e state_d;

      always_ff @(posedge clk) begin
        if (rst) begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end else begin
          state_q <= state_d;
          cnt_q   <= cnt_d;
        end
      end

      // Follow a change immediately, then ignore the input for the lockout window.
      always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        out_nxt = out_q[i];
        case (state_q)
          IDLE: begin
            if (s[i] != out_q[i]) begin
              out_nxt = s[i];
              state_d = LOCK;
              cnt_d   = CNT_W'(1);
            end
          end
          LOCK: begin
            if (cnt_q == CNT_LOCK) state_d = IDLE;
            else                   cnt_d   = cnt_q + CNT_W'(1);
          end
          default: state_d = IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q     <= in;
      rise_q    <= '0;
      fall_q    <= '0;
      changed_q <= 1'b0;
    end else begin
      out_q     <= out_d;
      rise_q    <= out_d & ~out_q;
      fall_q    <= ~out_d & out_q;
      changed_q <= |(out_d ^ out_q);
    end
  end

  assign out     = out_q;
  assign rise    = rise_q;
  assign fall    = fall_q;
  assign changed = changed_q;

endmodule

// File: tb/tb_debounce_array.sv
// Bench for debounce_array: one stable-count instance and one lockout instance,
// checked by directed tables/sequences and by randomized traffic against models.
module tb_debounce_array;

  localparam int DI = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] in_a, in_b;
  logic [3:0] out_a, rise_a, fall_a;
  logic [3:0] out_b, rise_b, fall_b;
  logic       changed_a, changed_b;

  always #5 clk = ~clk;

  debounce_array #(.N_CH(4), .DEBOUNCE_INTERVAL(DI), .SYNC_STAGES(2), .MODE(0)) dut_a (
    .clk(clk), .rst(rst), .in(in_a), .out(out_a), .rise(rise_a), .fall(fall_a),
    .changed(changed_a));

  debounce_array #(.N_CH(4), .DEBOUNCE_INTERVAL(DI), .SYNC_STAGES(0), .MODE(1)) dut_b (
    .clk(clk), .rst(rst), .in(in_b), .out(out_b), .rise(rise_b), .fall(fall_b),
    .changed(changed_b));

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Stable-count model: flip when the last DI synchronised samples all disagree with out.
  logic [3:0] pa0, pa1;
  logic [3:0] win_a[$];
  logic [3:0] ma_out, ma_rise, ma_fall;
  logic       ma_ch;

  // Lockout model: flip on disagreement if at least DI+1 edges since this channel last flipped.
  logic [3:0] mb_out, mb_rise, mb_fall;
  logic       mb_ch;
  int         last_b[4];
  int         edge_n = 0;

  task automatic tick();
    logic [3:0] s, nxt;
    bit         all_diff;
    if (rst) begin
      pa0 = in_a; pa1 = in_a; ma_out = in_a; ma_rise = '0; ma_fall = '0;
      win_a.delete();
    end else begin
      s = pa1;
      win_a.push_back(s);
      if (win_a.size() > DI) void'(win_a.pop_front());
      nxt = ma_out;
      for (int i = 0; i < 4; i++) begin
        if (win_a.size() == DI) begin
          all_diff = 1'b1;
          foreach (win_a[j]) if (win_a[j][i] == ma_out[i]) all_diff = 1'b0;
          if (all_diff) nxt[i] = ~ma_out[i];
        end
      end
      ma_rise = nxt & ~ma_out;
      ma_fall = ~nxt & ma_out;
      ma_out  = nxt;
      pa1 = pa0;
      pa0 = in_a;
    end
    ma_ch = |(ma_rise | ma_fall);

    if (rst) begin
      mb_out = in_b; mb_rise = '0; mb_fall = '0;
      for (int i = 0; i < 4; i++) last_b[i] = -1000;
    end else begin
      nxt = mb_out;
      for (int i = 0; i < 4; i++) begin
        if (in_b[i] != mb_out[i] && (edge_n - last_b[i]) >= DI + 1) begin
          nxt[i]    = in_b[i];
          last_b[i] = edge_n;
        end
      end
      mb_rise = nxt & ~mb_out;
      mb_fall = ~nxt & mb_out;
      mb_out  = nxt;
    end
    mb_ch = |(mb_rise | mb_fall);
    edge_n++;

    @(posedge clk);
    #1;
    check("model_a_out",     32'(out_a),     32'(ma_out));
    check("model_a_rise",    32'(rise_a),    32'(ma_rise));
    check("model_a_fall",    32'(fall_a),    32'(ma_fall));
    check("model_a_changed", 32'(changed_a), 32'(ma_ch));
    check("model_b_out",     32'(out_b),     32'(mb_out));
    check("model_b_rise",    32'(rise_b),    32'(mb_rise));
    check("model_b_fall",    32'(fall_b),    32'(mb_fall));
    check("model_b_changed", 32'(changed_b), 32'(mb_ch));
  endtask

  typedef struct packed {
    logic       rst;
    logic [3:0] in;
    logic [3:0] out;
    logic [3:0] rise;
    logic [3:0] fall;
    logic       ch;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic [3:0] i, input logic [3:0] o,
                     input logic [3:0] ri, input logic [3:0] fa, input logic c);
    vec_t v;
    v.rst = r; v.in = i; v.out = o; v.rise = ri; v.fall = fa; v.ch = c;
    tbl.push_back(v);
  endtask

  initial begin
    rst  = 1'b1;
    in_a = 4'b0000;
    in_b = 4'b1010;

    // Lockout instance: reset with a pattern, steady hold, one change, lockout, multi-channel change.
    add(1, 4'b1010, 4'b1010, 4'b0000, 4'b0000, 0);
    add(1, 4'b1010, 4'b1010, 4'b0000, 4'b0000, 0);
    add(0, 4'b1010, 4'b1010, 4'b0000, 4'b0000, 0);
    add(0, 4'b1010, 4'b1010, 4'b0000, 4'b0000, 0);
    add(0, 4'b1010, 4'b1010, 4'b0000, 4'b0000, 0);
    add(0, 4'b1011, 4'b1011, 4'b0001, 4'b0000, 1);
    for (int k = 0; k < 8; k++) add(0, 4'b1010, 4'b1011, 4'b0000, 4'b0000, 0);
    add(0, 4'b1010, 4'b1010, 4'b0000, 4'b0001, 1);
    add(0, 4'b0101, 4'b0100, 4'b0100, 4'b1010, 1);
    add(0, 4'b0101, 4'b0100, 4'b0000, 4'b0000, 0);

    foreach (tbl[n]) begin
      rst  = tbl[n].rst;
      in_b = tbl[n].in;
      tick();
      check("tbl_out",     32'(out_b),     32'(tbl[n].out));
      check("tbl_rise",    32'(rise_b),    32'(tbl[n].rise));
      check("tbl_fall",    32'(fall_b),    32'(tbl[n].fall));
      check("tbl_changed", 32'(changed_b), 32'(tbl[n].ch));
    end

    // Lockout instance: in[2] toggling every cycle transitions only at 1, 10, 19.
    rst = 1'b1; in_b = 4'b0000; tick();
    rst = 1'b0; tick(); tick();
    for (int k = 1; k <= 20; k++) begin
      in_b[2] = k[0];
      tick();
      check("tog_out2",  32'(out_b[2]),  32'((k < 10) || (k >= 19)));
      check("tog_rise2", 32'(rise_b[2]), 32'((k == 1) || (k == 19)));
      check("tog_fall2", 32'(fall_b[2]), 32'(k == 10));
    end
    in_b = 4'b0000;

    // Stable-count instance: single rise lands 2 sync + DI cycles after the input edge.
    in_a = 4'b0001;
    for (int k = 1; k <= 11; k++) begin
      tick();
      check("rise0_out",     32'(out_a),     32'((k >= 10) ? 4'b0001 : 4'b0000));
      check("rise0_rise",    32'(rise_a),    32'((k == 10) ? 4'b0001 : 4'b0000));
      check("rise0_changed", 32'(changed_a), 32'(k == 10));
      check("rise0_fall",    32'(fall_a),    32'(0));
    end

    // One-cycle dropout restarts qualification.
    in_a = 4'b0011;
    for (int k = 0; k < 7; k++) begin
      tick();
      check("glitch_out", 32'(out_a), 32'(4'b0001));
    end
    in_a = 4'b0001;
    tick();
    check("glitch_out", 32'(out_a), 32'(4'b0001));
    in_a = 4'b0011;
    for (int k = 1; k <= 12; k++) begin
      tick();
      check("glitch_out1",  32'(out_a[1]),  32'(k >= 10));
      check("glitch_rise1", 32'(rise_a[1]), 32'(k == 10));
    end

    // All channels released on one edge fall together.
    in_a = 4'b1111;
    for (int k = 0; k < 12; k++) tick();
    check("all_high", 32'(out_a), 32'(4'b1111));
    in_a = 4'b0000;
    for (int k = 1; k <= 10; k++) begin
      tick();
      check("all_fall", 32'(fall_a), 32'((k == 10) ? 4'b1111 : 4'b0000));
      check("all_out",  32'(out_a),  32'((k == 10) ? 4'b0000 : 4'b1111));
    end

    // Reset mid-qualification adopts the input level without a pulse.
    in_a = 4'b1000;
    for (int k = 0; k < 7; k++) tick();
    check("preq_out", 32'(out_a), 32'(4'b0000));
    rst = 1'b1;
    tick();
    check("rstq_out",  32'(out_a),  32'(4'b1000));
    check("rstq_rise", 32'(rise_a), 32'(0));
    rst = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick();
      check("postq_out",     32'(out_a),     32'(4'b1000));
      check("postq_rise",    32'(rise_a),    32'(0));
      check("postq_changed", 32'(changed_a), 32'(0));
    end

    // Randomized traffic with occasional resets.
    for (int k = 0; k < 3000; k++) begin
      rst = ($urandom_range(0, 399) == 0);
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(0, 9) == 0) in_a[i] = ~in_a[i];
        if ($urandom_range(0, 3) == 0) in_b[i] = ~in_b[i];
      end
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
